// File: rtl/multicycle_cpu_core.sv
// Multicycle 16-bit-instruction CPU core: IMEM, DMEM, 8-entry register file, ALU and
// FSM controller. Free-run or single-step execution; IMEM loadable while idle.
module multicycle_cpu_core #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned IMEM_AW = 6,
    parameter int unsigned DMEM_AW = 6
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               mode_run_i,
    input  logic               step_i,
    input  logic               prog_we_i,
    input  logic [IMEM_AW-1:0] prog_addr_i,
    input  logic [15:0]        prog_data_i,
    input  logic [2:0]         reg_select_i,
    output logic [IMEM_AW-1:0] pc_out_o,
    output logic [15:0]        instr_out_o,
    output logic [DATA_W-1:0]  reg_debug_o,
    output logic               zero_flag_o,
    output logic               halted_o,
    output logic               busy_o,
    output logic               retire_o
);
    localparam int unsigned ImemDepth = 1 << IMEM_AW;
    localparam int unsigned DmemDepth = 1 << DMEM_AW;

    localparam logic [3:0] OpAdd   = 4'h1;
    localparam logic [3:0] OpSub   = 4'h2;
    localparam logic [3:0] OpAnd   = 4'h3;
    localparam logic [3:0] OpOr    = 4'h4;
    localparam logic [3:0] OpXor   = 4'h5;
    localparam logic [3:0] OpAddi  = 4'h6;
    localparam logic [3:0] OpLdi   = 4'h7;
    localparam logic [3:0] OpJmp   = 4'h8;
    localparam logic [3:0] OpBeqz  = 4'h9;
    localparam logic [3:0] OpLoad  = 4'hC;
    localparam logic [3:0] OpStore = 4'hD;
    localparam logic [3:0] OpHalt  = 4'hF;

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

    state_e              state_q, state_d;
    logic [IMEM_AW-1:0]  pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic                z_q, z_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
    logic                step_req_q, step_req_d;
    logic [2:0]          step_sync_q;

    logic [DATA_W-1:0]   rf_q   [8];
    logic [DATA_W-1:0]   dmem_q [DmemDepth];
    logic [15:0]         imem_q [ImemDepth];

    logic                rf_we, dmem_we, busy, retire, fetch_accept, step_edge;
    logic [DATA_W-1:0]   rf_wdata, alu_res;

    logic [3:0]          op;
    logic [2:0]          rd, rs, rt;
    logic [DATA_W-1:0]   imm6_s, imm9_z;
    logic [IMEM_AW-1:0]  br_off;
    logic [DMEM_AW-1:0]  dmem_addr;

    assign op        = ir_q[15:12];
    assign rd        = ir_q[11:9];
    assign rs        = ir_q[8:6];
    assign rt        = ir_q[5:3];
    assign imm6_s    = DATA_W'($signed(ir_q[5:0]));
    assign imm9_z    = DATA_W'(ir_q[8:0]);
    assign br_off    = IMEM_AW'($signed(ir_q[8:0]));
    assign dmem_addr = alu_q[DMEM_AW-1:0];

    assign step_edge    = step_sync_q[1] & ~step_sync_q[2];
    assign fetch_accept = (state_q == StFetch) && (mode_run_i || step_req_q);

    // Step requests are only taken while waiting in FETCH; edges during an instruction
    // merge into the one being executed. Run mode discards any pending request.
    always_comb begin
        step_req_d = step_req_q;
        if (state_q == StFetch && step_edge) step_req_d = 1'b1;
        if (mode_run_i || fetch_accept) step_req_d = 1'b0;
    end

    // ALU: LOAD/STORE reuse the ADDI path for the effective address.
    always_comb begin
        alu_res = '0;
        case (op)
            OpAdd:            alu_res = a_q + b_q;
            OpSub:            alu_res = a_q - b_q;
            OpAnd:            alu_res = a_q & b_q;
            OpOr:             alu_res = a_q | b_q;
            OpXor:            alu_res = a_q ^ b_q;
            OpAddi, OpLoad,
            OpStore:          alu_res = a_q + imm6_s;
            OpLdi:            alu_res = imm9_z;
            default:          alu_res = '0;
        endcase
    end

    // Controller next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        z_d      = z_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        rf_we    = 1'b0;
        rf_wdata = alu_q;
        dmem_we  = 1'b0;
        retire   = 1'b0;
        busy     = 1'b1;
        case (state_q)
            StFetch: begin
                if (fetch_accept) begin
                    ir_d    = imem_q[pc_q];
                    pc_d    = pc_q + IMEM_AW'(1);
                    state_d = StDecode;
                end else begin
                    busy = 1'b0;
                end
            end
            StDecode: begin
                a_d     = rf_q[rs];
                b_d     = (op == OpStore || op == OpBeqz) ? rf_q[rd] : rf_q[rt];
                state_d = StExec;
            end
            StExec: begin
                alu_d = alu_res;
                case (op)
                    OpAdd, OpSub, OpAnd, OpOr, OpXor, OpAddi, OpLdi: begin
                        z_d     = (alu_res == '0);
                        state_d = StWb;
                    end
                    OpLoad, OpStore: state_d = StMem;
                    OpJmp: begin
                        pc_d    = ir_q[IMEM_AW-1:0];
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    OpBeqz: begin
                        if (b_q == '0) pc_d = pc_q + br_off;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    OpHalt: begin
                        retire  = 1'b1;
                        state_d = StHalt;
                    end
                    default: begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StMem: begin
                if (op == OpStore) begin
                    dmem_we = 1'b1;
                    retire  = 1'b1;
                    state_d = StFetch;
                end else begin
                    mdr_d   = dmem_q[dmem_addr];
                    state_d = StWb;
                end
            end
            StWb: begin
                rf_we    = (rd != 3'd0);
                rf_wdata = (op == OpLoad) ? mdr_q : alu_q;
                retire   = 1'b1;
                state_d  = StFetch;
            end
            StHalt:  busy = 1'b0;
            default: state_d = StFetch;
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StFetch;
            pc_q        <= '0;
            ir_q        <= '0;
            z_q         <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            alu_q       <= '0;
            mdr_q       <= '0;
            step_req_q  <= 1'b0;
            step_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            z_q         <= z_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_q       <= alu_d;
            mdr_q       <= mdr_d;
            step_req_q  <= step_req_d;
            step_sync_q <= {step_sync_q[1:0], step_i};
        end
    end

    // Register file; R0 is never written so it always reads zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else if (rf_we) begin
            rf_q[rd] <= rf_wdata;
        end
    end

    // Data memory.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DmemDepth; i++) dmem_q[i] <= '0;
        end else if (dmem_we) begin
            dmem_q[dmem_addr] <= b_q;
        end
    end

    // Instruction memory survives reset; loads only while the core is idle.
    always_ff @(posedge clk_i) begin
        if (prog_we_i && !busy) imem_q[prog_addr_i] <= prog_data_i;
    end

    assign pc_out_o    = pc_q;
    assign instr_out_o = ir_q;
    assign reg_debug_o = rf_q[reg_select_i];
    assign zero_flag_o = z_q;
    assign halted_o    = (state_q == StHalt);
    assign busy_o      = busy;
    assign retire_o    = retire;

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Directed, table-driven bench for multicycle_cpu_core.
module tb_multicycle_cpu_core;
    logic        clk = 1'b0;
    logic        rst_n, mode_run, step, prog_we;
    logic [5:0]  prog_addr;
    logic [15:0] prog_data;
    logic [2:0]  reg_select;
    logic [5:0]  pc_out;
    logic [15:0] instr_out, reg_debug;
    logic        zero_flag, halted, busy, retire;

    multicycle_cpu_core #(.DATA_W(16), .IMEM_AW(6), .DMEM_AW(6)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .mode_run_i  (mode_run),
        .step_i      (step),
        .prog_we_i   (prog_we),
        .prog_addr_i (prog_addr),
        .prog_data_i (prog_data),
        .reg_select_i(reg_select),
        .pc_out_o    (pc_out),
        .instr_out_o (instr_out),
        .reg_debug_o (reg_debug),
        .zero_flag_o (zero_flag),
        .halted_o    (halted),
        .busy_o      (busy),
        .retire_o    (retire)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [8:0]  a;
        logic [8:0]  b;
        logic [15:0] exp;
        logic        exp_z;
    } vec_t;

    vec_t        vecs [12];
    logic [15:0] prog [$];
    int          ret_idx [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          ret_cnt = 0;
    logic [15:0] rv;

    localparam logic [15:0] Halt = 16'hF000;

    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 3'b000};
    endfunction

    function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [5:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [15:0] enc_ldi(input logic [2:0] rd, input logic [8:0] imm);
        return {4'h7, rd, imm};
    endfunction

    function automatic logic [15:0] enc_beqz(input logic [2:0] rd, input logic [8:0] off);
        return {4'h9, rd, off};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic rd_reg(input logic [2:0] r, output logic [15:0] v);
        reg_select = r;
        #1;
        v = reg_debug;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (retire) ret_cnt++;
        end
    endtask

    task automatic do_reset();
        mode_run = 1'b0;
        step     = 1'b0;
        prog_we  = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_prog();
        for (int i = 0; i < prog.size(); i++) begin
            prog_we   = 1'b1;
            prog_addr = 6'(i);
            prog_data = prog[i];
            @(negedge clk);
        end
        prog_we = 1'b0;
    endtask

    // Free-runs until HALT, logging the sample index of each retire pulse.
    task automatic run_to_halt(input int bound);
        logic done;
        done = 1'b0;
        ret_idx.delete();
        mode_run = 1'b1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (retire) ret_idx.push_back(i);
            if (halted) begin
                done = 1'b1;
                break;
            end
        end
        mode_run = 1'b0;
        check("halt_reached", 32'(done), 32'd1);
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick(3);
        step = 1'b0;
        tick(12);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; mode_run = 1'b0; step = 1'b0; prog_we = 1'b0;
        prog_addr = '0; prog_data = '0; reg_select = '0;

        vecs[0]  = '{4'h1, 9'd5,    9'd3,    16'h0008, 1'b0};
        vecs[1]  = '{4'h2, 9'd5,    9'd5,    16'h0000, 1'b1};
        vecs[2]  = '{4'h2, 9'd3,    9'd5,    16'hFFFE, 1'b0};
        vecs[3]  = '{4'h3, 9'h1F0,  9'h0FF,  16'h00F0, 1'b0};
        vecs[4]  = '{4'h3, 9'h100,  9'h0FF,  16'h0000, 1'b1};
        vecs[5]  = '{4'h4, 9'h100,  9'h00F,  16'h010F, 1'b0};
        vecs[6]  = '{4'h5, 9'h1FF,  9'h1FF,  16'h0000, 1'b1};
        vecs[7]  = '{4'h5, 9'h155,  9'h0AA,  16'h01FF, 1'b0};
        vecs[8]  = '{4'h6, 9'd5,    9'h03F,  16'h0004, 1'b0};
        vecs[9]  = '{4'h6, 9'd0,    9'h03F,  16'hFFFF, 1'b0};
        vecs[10] = '{4'h6, 9'd1,    9'h03F,  16'h0000, 1'b1};
        vecs[11] = '{4'h1, 9'h1FF,  9'h1FF,  16'h03FE, 1'b0};

        // Reset state
        do_reset();
        check("rst_pc", 32'(pc_out), 32'd0);
        check("rst_ir", 32'(instr_out), 32'd0);
        check("rst_z", 32'(zero_flag), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);

        // ALU table: LDI R1,a; LDI R2,b; op R3; HALT
        for (int v = 0; v < 12; v++) begin
            do_reset();
            prog = {enc_ldi(3'd1, vecs[v].a), enc_ldi(3'd2, vecs[v].b),
                    (vecs[v].op == 4'h6) ? enc_i(4'h6, 3'd3, 3'd1, vecs[v].b[5:0])
                                         : enc_r(vecs[v].op, 3'd3, 3'd1, 3'd2),
                    Halt};
            load_prog();
            run_to_halt(100);
            rd_reg(3'd3, rv);
            check($sformatf("alu%0d_r3", v), 32'(rv), 32'(vecs[v].exp));
            check($sformatf("alu%0d_z", v), 32'(zero_flag), 32'(vecs[v].exp_z));
            check($sformatf("alu%0d_retires", v), 32'(ret_idx.size()), 32'd4);
            check($sformatf("alu%0d_pc", v), 32'(pc_out), 32'd4);
        end

        // SUB to zero, ADDI all-ones from R0, write to R0 discarded
        do_reset();
        prog = {enc_ldi(3'd1, 9'd5), enc_r(4'h2, 3'd4, 3'd1, 3'd1),
                enc_i(4'h6, 3'd5, 3'd0, 6'h3F), enc_ldi(3'd0, 9'd7), Halt};
        load_prog();
        run_to_halt(100);
        rd_reg(3'd4, rv); check("sub_r4", 32'(rv), 32'h0000);
        rd_reg(3'd5, rv); check("addi_r5", 32'(rv), 32'hFFFF);
        rd_reg(3'd0, rv); check("r0_zero", 32'(rv), 32'h0000);
        check("z_after_ldi_r0", 32'(zero_flag), 32'd0);

        // STORE/LOAD and their latencies
        do_reset();
        prog = {enc_ldi(3'd1, 9'd5), enc_i(4'hD, 3'd1, 3'd0, 6'd2),
                enc_i(4'hC, 3'd6, 3'd0, 6'd2), enc_ldi(3'd2, 9'd10),
                enc_i(4'hD, 3'd1, 3'd2, 6'h3F), enc_i(4'hC, 3'd7, 3'd0, 6'd9),
                enc_i(4'hC, 3'd4, 3'd0, 6'd3), Halt};
        load_prog();
        run_to_halt(200);
        rd_reg(3'd6, rv); check("load_r6", 32'(rv), 32'd5);
        rd_reg(3'd7, rv); check("load_neg_off_r7", 32'(rv), 32'd5);
        rd_reg(3'd4, rv); check("load_empty_r4", 32'(rv), 32'd0);
        check("mem_retires", 32'(ret_idx.size()), 32'd8);
        if (ret_idx.size() >= 3) begin
            check("store_latency", 32'(ret_idx[1] - ret_idx[0]), 32'd4);
            check("load_latency", 32'(ret_idx[2] - ret_idx[1]), 32'd5);
        end else begin
            check("mem_retire_log", 32'(ret_idx.size()), 32'd3);
        end

        // BEQZ not taken / taken
        do_reset();
        prog = {enc_ldi(3'd1, 9'd1), enc_beqz(3'd1, 9'd1), enc_ldi(3'd2, 9'd7),
                enc_beqz(3'd0, 9'd1), enc_ldi(3'd3, 9'd9), Halt};
        load_prog();
        run_to_halt(100);
        rd_reg(3'd2, rv); check("beqz_nt_r2", 32'(rv), 32'd7);
        rd_reg(3'd3, rv); check("beqz_t_r3", 32'(rv), 32'd0);
        check("beqz_pc", 32'(pc_out), 32'd6);
        check("beqz_retires", 32'(ret_idx.size()), 32'd5);

        // BEQZ R0,-1 self-loop; prog_we while running is ignored
        do_reset();
        prog = {enc_beqz(3'd0, 9'h1FF)};
        load_prog();
        mode_run  = 1'b1;
        ret_cnt   = 0;
        prog_we   = 1'b1;
        prog_addr = 6'd0;
        prog_data = Halt;
        tick(30);
        prog_we  = 1'b0;
        check("loop_retires", 32'(ret_cnt), 32'd10);
        check("loop_not_halted", 32'(halted), 32'd0);
        mode_run = 1'b0;
        tick(5);
        check("loop_pc", 32'(pc_out), 32'd0);
        check("loop_idle_busy", 32'(busy), 32'd0);
        pulse_step();
        check("prog_we_ignored_ir", 32'(instr_out), 32'(enc_beqz(3'd0, 9'h1FF)));
        check("prog_we_ignored_halt", 32'(halted), 32'd0);
        prog_we = 1'b1;
        tick(1);
        prog_we = 1'b0;
        pulse_step();
        check("prog_we_idle_halt", 32'(halted), 32'd1);

        // JMP 63 then NOP: PC wraps to 0 (step mode)
        do_reset();
        prog.delete();
        for (int i = 0; i < 64; i++) prog.push_back(16'h0000);
        prog[0] = {4'h8, 12'd63};
        load_prog();
        ret_cnt = 0;
        pulse_step();
        check("jmp_pc", 32'(pc_out), 32'd63);
        pulse_step();
        check("wrap_pc", 32'(pc_out), 32'd0);
        check("wrap_retires", 32'(ret_cnt), 32'd2);

        // Step mode: three edges, three retires; a glitchy double edge retires once
        do_reset();
        prog = {enc_ldi(3'd1, 9'd1), enc_ldi(3'd2, 9'd2), enc_ldi(3'd3, 9'd3), Halt};
        load_prog();
        ret_cnt = 0;
        for (int s = 0; s < 3; s++) begin
            pulse_step();
            check($sformatf("step%0d_busy", s), 32'(busy), 32'd0);
        end
        check("step_retires", 32'(ret_cnt), 32'd3);
        check("step_pc", 32'(pc_out), 32'd3);
        rd_reg(3'd3, rv); check("step_r3", 32'(rv), 32'd3);
        ret_cnt = 0;
        step = 1'b1; tick(1);
        step = 1'b0; tick(1);
        step = 1'b1; tick(1);
        step = 1'b0; tick(12);
        check("glitch_retires", 32'(ret_cnt), 32'd1);
        check("glitch_halted", 32'(halted), 32'd1);

        // Reset during WB of ADD
        do_reset();
        prog = {enc_ldi(3'd1, 9'd5), enc_ldi(3'd2, 9'd3), enc_r(4'h1, 3'd3, 3'd1, 3'd2), Halt};
        load_prog();
        mode_run = 1'b1;
        ret_cnt  = 0;
        tick(11);
        check("wb_reached", 32'(ret_cnt), 32'd3);
        check("wb_ir_add", 32'(instr_out), 32'(enc_r(4'h1, 3'd3, 3'd1, 3'd2)));
        rst_n    = 1'b0;
        mode_run = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        rd_reg(3'd3, rv); check("rst_wb_r3", 32'(rv), 32'd0);
        check("rst_wb_pc", 32'(pc_out), 32'd0);
        check("rst_wb_ir", 32'(instr_out), 32'd0);
        check("rst_wb_busy", 32'(busy), 32'd0);
        check("rst_wb_halted", 32'(halted), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
